// File: rtl/ddr3_mcb_cmd_ctl_mb.sv
// Multi-bank open-page DDR3 command controller: tracks the open row per bank and
// sequences PREA/REF/PRE/ACT/RD/WR strobes with parametrised command spacing.
module ddr3_mcb_cmd_ctl_mb #(
   parameter  int NBANK  = 8,
   parameter  int ROW_W  = 14,
   parameter  int BSTN_W = 2,
   parameter  int CtRP   = 5,
   parameter  int CtRCD  = 5,
   parameter  int CtRFC  = 44,
   parameter  int CtCCD  = 4,
   parameter  int CNT_W  = 6,
   localparam int BA_W   = $clog2(NBANK)
) (
   input  logic              ddr3_mcb_clk,
   input  logic              ddr3_mcb_rst_n,
   input  logic              i_ready,
   input  logic              ref_req,
   input  logic              ref_alert,
   input  logic              ddr3_mcb_bb,
   input  logic              ddr3_mcb_wr_n,
   input  logic [BA_W-1:0]   ddr3_mcb_ba,
   input  logic [ROW_W-1:0]  ddr3_mcb_row,
   input  logic [BSTN_W-1:0] ddr3_mcb_bstn,
   output logic              ddr3_mcb_busy,
   output logic              c_ready,
   output logic              c_prea,
   output logic              c_ref,
   output logic              c_prec,
   output logic              c_act,
   output logic              c_rd,
   output logic              c_wr,
   output logic [BA_W-1:0]   c_ba,
   output logic [ROW_W-1:0]  c_row,
   output logic              c_wdat_req
);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_PREA, S_WRP_A, S_REF, S_WRFC,
      S_PREC, S_WRP, S_ACT, S_WRCD, S_RW, S_WCCD
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q;
   logic [BA_W-1:0]     ba_q;
   logic [ROW_W-1:0]    row_q;
   logic [BSTN_W-1:0]   bst_q;
   logic [NBANK-1:0]    open_vld_q;
   logic [ROW_W-1:0]    open_row_q [NBANK];

   logic idle, accept, hit, last_rcd, last_ccd;

   assign idle          = (state_q == S_IDLE);
   assign ddr3_mcb_busy = ~(idle & ~ref_req & ~ref_alert);
   assign accept        = ddr3_mcb_bb & ~ddr3_mcb_busy;
   assign hit           = open_vld_q[ddr3_mcb_ba] && (open_row_q[ddr3_mcb_ba] == ddr3_mcb_row);
   assign last_rcd      = (cnt_q == CNT_W'(CtRCD - 2));
   assign last_ccd      = (cnt_q == CNT_W'(CtCCD - 2));

   // NOTE: every next-state variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT:  if (i_ready) state_d = S_IDLE;
         S_IDLE: begin
            if (ref_req)     state_d = (|open_vld_q) ? S_PREA : S_REF;
            else if (accept) state_d = hit ? S_RW : (open_vld_q[ddr3_mcb_ba] ? S_PREC : S_ACT);
         end
         S_PREA:  state_d = S_WRP_A;
         S_WRP_A: if (cnt_q == CNT_W'(CtRP - 2))  state_d = S_REF;
         S_REF:   state_d = S_WRFC;
         S_WRFC:  if (cnt_q == CNT_W'(CtRFC - 2)) state_d = S_IDLE;
         S_PREC:  state_d = S_WRP;
         S_WRP:   if (cnt_q == CNT_W'(CtRP - 2))  state_d = S_ACT;
         S_ACT:   state_d = S_WRCD;
         S_WRCD:  if (last_rcd) state_d = S_RW;
         S_RW:    state_d = (bst_q == '0) ? S_IDLE : S_WCCD;
         S_WCCD:  if (last_ccd) state_d = S_RW;
         default: state_d = S_INIT;
      endcase
      // Every wait state is entered from a different state, so a state change restarts the interval.
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
   end

   assign c_ready    = idle;
   assign c_prea     = (state_q == S_PREA);
   assign c_ref      = (state_q == S_REF);
   assign c_prec     = (state_q == S_PREC);
   assign c_act      = (state_q == S_ACT);
   assign c_rd       = (state_q == S_RW) &  wr_q;
   assign c_wr       = (state_q == S_RW) & ~wr_q;
   assign c_ba       = (c_prec | c_act | (state_q == S_RW)) ? ba_q : '0;
   assign c_row      = c_act ? row_q : '0;
   assign c_wdat_req = (idle & accept & hit & ~ddr3_mcb_wr_n)
                     | ((state_q == S_WRCD) & ~wr_q & last_rcd)
                     | ((state_q == S_WCCD) & ~wr_q & last_ccd);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ddr3_mcb_clk) begin
      if (!ddr3_mcb_rst_n) begin
         state_q    <= S_INIT;
         cnt_q      <= '0;
         wr_q       <= 1'b1;
         ba_q       <= '0;
         row_q      <= '0;
         bst_q      <= '0;
         open_vld_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q  <= ddr3_mcb_wr_n;
            ba_q  <= ddr3_mcb_ba;
            row_q <= ddr3_mcb_row;
            bst_q <= ddr3_mcb_bstn;
         end else if (state_q == S_RW) begin
            bst_q <= bst_q - 1'b1;
         end
         unique case (state_q)
            S_PREA:  open_vld_q       <= '0;
            S_PREC:  open_vld_q[ba_q] <= 1'b0;
            S_ACT:   open_vld_q[ba_q] <= 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the row table is not reset; its valid bits are, so stale rows are never trusted.
   always_ff @(posedge ddr3_mcb_clk) begin
      if (state_q == S_ACT) open_row_q[ba_q] <= row_q;
   end

endmodule

// File: tb/tb_ddr3_mcb_cmd_ctl_mb.sv
// Directed bench for ddr3_mcb_cmd_ctl_mb: strobe ordering, spacing, open-table hit/miss/empty, refresh, reset.
module tb_ddr3_mcb_cmd_ctl_mb;

   localparam int BA_W  = 3;
   localparam int ROW_W = 14;

   localparam int SEL_ACT = 0, SEL_RD = 1, SEL_WR = 2, SEL_REF = 3, SEL_READY = 4;

   logic              clk = 1'b0;
   logic              rst_n, i_ready, ref_req, ref_alert, bb, wr_n;
   logic [BA_W-1:0]   ba;
   logic [ROW_W-1:0]  row;
   logic [1:0]        bstn;
   logic              busy, c_ready, c_prea, c_ref, c_prec, c_act, c_rd, c_wr, c_wdat_req;
   logic [BA_W-1:0]   c_ba;
   logic [ROW_W-1:0]  c_row;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ddr3_mcb_cmd_ctl_mb dut (
      .ddr3_mcb_clk   (clk),
      .ddr3_mcb_rst_n (rst_n),
      .i_ready        (i_ready),
      .ref_req        (ref_req),
      .ref_alert      (ref_alert),
      .ddr3_mcb_bb    (bb),
      .ddr3_mcb_wr_n  (wr_n),
      .ddr3_mcb_ba    (ba),
      .ddr3_mcb_row   (row),
      .ddr3_mcb_bstn  (bstn),
      .ddr3_mcb_busy  (busy),
      .c_ready        (c_ready),
      .c_prea         (c_prea),
      .c_ref          (c_ref),
      .c_prec         (c_prec),
      .c_act          (c_act),
      .c_rd           (c_rd),
      .c_wr           (c_wr),
      .c_ba           (c_ba),
      .c_row          (c_row),
      .c_wdat_req     (c_wdat_req)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] strobes();
      return {c_prea, c_ref, c_prec, c_act, c_rd, c_wr};
   endfunction

   function automatic logic sel_hit(input int sel);
      case (sel)
         SEL_ACT:   return c_act;
         SEL_RD:    return c_rd;
         SEL_WR:    return c_wr;
         SEL_REF:   return c_ref;
         default:   return c_ready;
      endcase
   endfunction

   // Clocks until the selected output appears; n = -1 if the budget expires.
   task automatic run_until(input int sel, input int max, output int n,
                            output logic prev_wd, output logic act_seen);
      n = -1; prev_wd = 1'b0; act_seen = 1'b0;
      for (int i = 1; i <= max; i++) begin
         prev_wd = c_wdat_req;
         tick();
         if (sel_hit(sel)) begin
            n = i;
            break;
         end
         act_seen |= c_act;
      end
   endtask

   task automatic request(input logic w_n, input logic [BA_W-1:0] b,
                          input logic [ROW_W-1:0] r, input logic [1:0] bn);
      bb = 1'b1; wr_n = w_n; ba = b; row = r; bstn = bn;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic pwd, act_seen, bad;

      rst_n = 1'b0; i_ready = 1'b0; ref_req = 1'b0; ref_alert = 1'b0;
      bb = 1'b0; wr_n = 1'b1; ba = '0; row = '0; bstn = '0;
      #1;
      tick(); tick();
      check("reset_busy", busy, 1'b1);
      check("reset_ready", c_ready, 1'b0);
      check("reset_outs", {strobes(), c_ba, c_row, c_wdat_req}, '0);

      // INIT holds while the PHY is not ready
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (!busy || c_ready || strobes() != '0) bad = 1'b1;
      end
      check("init_hold", bad, 1'b0);
      i_ready = 1'b1;
      tick();
      check("init_ready", c_ready, 1'b1);
      check("idle_busy", busy, 1'b0);

      // Request held under ref_alert is ignored until the alert drops
      ref_alert = 1'b1;
      request(1'b1, 3'd2, 14'h100, 2'd0);
      #1 check("alert_busy", busy, 1'b1);
      tick();
      check("alert_no_cmd", {c_ready, strobes()}, {1'b1, 6'b0});
      ref_alert = 1'b0;

      // Empty bank 2, read row 0x100
      tick();
      bb = 1'b0;
      check("t2_act", c_act, 1'b1);
      check("t2_act_ba", c_ba, 3'd2);
      check("t2_act_row", c_row, 14'h100);
      run_until(SEL_RD, 20, n, pwd, act_seen);
      check("t2_act_to_rd", n, 5);
      check("t2_rd_ba", c_ba, 3'd2);
      check("t2_rd_no_wdat", pwd, 1'b0);
      tick();
      check("t2_idle", c_ready, 1'b1);

      // Hit: write bank 2 row 0x100, four bursts
      request(1'b0, 3'd2, 14'h100, 2'd3);
      #1 check("t3_wdat_accept", c_wdat_req, 1'b1);
      tick();
      bb = 1'b0;
      check("t3_wr0", {c_act, c_wr}, 2'b01);
      check("t3_wr0_ba", c_ba, 3'd2);
      for (int k = 1; k < 4; k++) begin
         run_until(SEL_WR, 10, n, pwd, act_seen);
         check($sformatf("t3_wr%0d_gap", k), n, 4);
         check($sformatf("t3_wr%0d_wdat", k), pwd, 1'b1);
         check($sformatf("t3_wr%0d_noact", k), act_seen, 1'b0);
      end
      tick();
      check("t3_idle", c_ready, 1'b1);

      // Miss: bank 2 row 0x200
      request(1'b1, 3'd2, 14'h200, 2'd0);
      tick();
      bb = 1'b0;
      check("t4_prec", {c_prec, c_ba}, {1'b1, 3'd2});
      run_until(SEL_ACT, 10, n, pwd, act_seen);
      check("t4_prec_to_act", n, 5);
      check("t4_act_row", c_row, 14'h200);
      run_until(SEL_RD, 10, n, pwd, act_seen);
      check("t4_act_to_rd", n, 5);
      tick();
      request(1'b1, 3'd2, 14'h200, 2'd0);
      tick();
      bb = 1'b0;
      check("t4_table_hit", {c_act, c_rd}, 2'b01);
      tick();

      // Refresh with a bank open
      ref_req = 1'b1;
      #1 check("t5_busy", busy, 1'b1);
      tick();
      check("t5_prea", c_prea, 1'b1);
      run_until(SEL_REF, 10, n, pwd, act_seen);
      check("t5_prea_to_ref", n, 5);
      ref_req = 1'b0;
      run_until(SEL_READY, 60, n, pwd, act_seen);
      check("t5_ref_to_idle", n, 44);
      request(1'b0, 3'd2, 14'h200, 2'd0);
      tick();
      bb = 1'b0;
      check("t5_bank_empty_act", c_act, 1'b1);
      run_until(SEL_WR, 10, n, pwd, act_seen);
      check("t5_act_to_wr", n, 5);
      check("t5_wdat_in_wrcd", pwd, 1'b1);
      tick();

      // Reset during WRCD
      request(1'b1, 3'd5, 14'h033, 2'd0);
      tick();
      bb = 1'b0;
      check("t6_act", {c_act, c_ba}, {1'b1, 3'd5});
      tick(); tick();
      rst_n = 1'b0; i_ready = 1'b0;
      tick();
      check("t6_rst_outs", {strobes(), c_ba, c_row, c_wdat_req, c_ready}, '0);
      check("t6_rst_busy", busy, 1'b1);
      rst_n = 1'b1; i_ready = 1'b1;
      tick();
      check("t6_ready", c_ready, 1'b1);
      request(1'b1, 3'd2, 14'h200, 2'd0);
      tick();
      bb = 1'b0;
      check("t6_table_cleared_act", c_act, 1'b1);
      run_until(SEL_RD, 10, n, pwd, act_seen);
      check("t6_act_to_rd", n, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
